// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: UART character receiver with a small command decoder.
// Characters are received 8N1-style (LSB first, one stop bit). A write command
// is followed by a fixed number of payload characters that are assembled and
// published on wr_data. A read command raises a single strobe. Stop-bit errors
// and payload inactivity are reported on frm_err.
`timescale 1ns/1ps

module uart_cmd_rx #(
  parameter int                   CLK_PER_BIT   = 28,
  parameter int                   DATA_BITS     = 8,
  parameter int                   PAYLOAD_BYTES = 4,
  parameter logic [DATA_BITS-1:0] CMD_WR        = DATA_BITS'(8'h55),
  parameter logic [DATA_BITS-1:0] CMD_RD        = DATA_BITS'(8'hAA),
  parameter int                   TIMEOUT_BITS  = 20
) (
  input  logic                               sclk,
  input  logic                               s_rst,
  input  logic                               rs232_rx,
  output logic [DATA_BITS-1:0]               rx_data,
  output logic                               rx_vld,
  output logic                               wr_trig,
  output logic [PAYLOAD_BYTES*DATA_BITS-1:0] wr_data,
  output logic                               rd_trig,
  output logic                               frm_err
);

  localparam int CW        = (CLK_PER_BIT > 2) ? $clog2(CLK_PER_BIT) : 1;
  localparam int BW        = (DATA_BITS > 2) ? $clog2(DATA_BITS) : 1;
  localparam int IW        = (PAYLOAD_BYTES > 2) ? $clog2(PAYLOAD_BYTES) : 1;
  localparam int TO_CYCLES = TIMEOUT_BITS * CLK_PER_BIT;
  localparam int TW        = (TO_CYCLES > 2) ? $clog2(TO_CYCLES) : 1;

  localparam logic [CW-1:0] CNT_HALF = CW'(CLK_PER_BIT / 2);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(PAYLOAD_BYTES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TO_CYCLES - 1);

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic {
    DEC_CMD,
    DEC_PAYLOAD
  } dec_state_t;

  // Line synchroniser plus one extra stage for falling-edge detection.
  logic rx_meta;
  logic rx_sync;
  logic rx_prev;

  // Receiver state.
  rx_state_t              rx_state;
  logic [CW-1:0]          clk_cnt;
  logic [BW-1:0]          bit_cnt;
  logic [DATA_BITS-1:0]   shreg;
  logic                   stop_err;
  logic                   start_edge;

  // Decoder state.
  dec_state_t                         dec_state;
  logic [IW-1:0]                      byte_idx;
  logic [TW-1:0]                      idle_cnt;
  logic [PAYLOAD_BYTES*DATA_BITS-1:0] shadow;
  logic [PAYLOAD_BYTES*DATA_BITS-1:0] shadow_next;
  int                                 lane_lsb;

  assign start_edge = (rx_state == RX_IDLE) && rx_prev && !rx_sync;

  // Bring the asynchronous line into the sclk domain; idle level is high.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge sclk) begin
    if (s_rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rs232_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Character receiver: find the start edge, then sample every bit at mid-bit.
  always_ff @(posedge sclk) begin
    if (s_rst) begin
      rx_state <= RX_IDLE;
      clk_cnt  <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      rx_data  <= '0;
      rx_vld   <= 1'b0;
      stop_err <= 1'b0;
    end else begin
      rx_vld   <= 1'b0;
      stop_err <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          clk_cnt <= '0;
          bit_cnt <= '0;
          if (start_edge) begin
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (clk_cnt == CNT_HALF) begin
            clk_cnt  <= '0;
            // A line that is high again at mid start bit was only a glitch.
            rx_state <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (clk_cnt == CNT_LAST) begin
            clk_cnt <= '0;
            shreg   <= {rx_sync, shreg[DATA_BITS-1:1]};
            if (bit_cnt == BIT_LAST) begin
              bit_cnt  <= '0;
              rx_state <= RX_STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (clk_cnt == CNT_LAST) begin
            clk_cnt <= '0;
            if (rx_sync) begin
              rx_data <= shreg;
              rx_vld  <= 1'b1;
            end else begin
              stop_err <= 1'b1;
            end
            // Leaving at mid stop bit lets a start edge in its second half through.
            rx_state <= RX_IDLE;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // Payload lane for the current character: the first character lands in the MSB lane.
  // NOTE: every always_comb output is assigned a default first so no latch is inferred.
  always_comb begin
    shadow_next = shadow;
    lane_lsb    = (PAYLOAD_BYTES - 1 - int'(byte_idx)) * DATA_BITS;
    shadow_next[lane_lsb +: DATA_BITS] = rx_data;
  end

  // Command decoder: acts on rx_vld / stop errors / idle timeout, strobes one cycle later.
  always_ff @(posedge sclk) begin
    if (s_rst) begin
      dec_state <= DEC_CMD;
      byte_idx  <= '0;
      idle_cnt  <= '0;
      shadow    <= '0;
      wr_data   <= '0;
      wr_trig   <= 1'b0;
      rd_trig   <= 1'b0;
      frm_err   <= 1'b0;
    end else begin
      wr_trig <= 1'b0;
      rd_trig <= 1'b0;
      frm_err <= 1'b0;
      if (stop_err) begin
        // A broken character aborts any partial payload.
        frm_err   <= 1'b1;
        dec_state <= DEC_CMD;
        byte_idx  <= '0;
        idle_cnt  <= '0;
      end else if (rx_vld) begin
        idle_cnt <= '0;
        case (dec_state)
          DEC_CMD: begin
            if (rx_data == CMD_WR) begin
              dec_state <= DEC_PAYLOAD;
              byte_idx  <= '0;
            end else if (rx_data == CMD_RD) begin
              rd_trig <= 1'b1;
            end
          end
          DEC_PAYLOAD: begin
            // Command codes inside a payload are plain data.
            shadow <= shadow_next;
            if (byte_idx == IDX_LAST) begin
              wr_data   <= shadow_next;
              wr_trig   <= 1'b1;
              dec_state <= DEC_CMD;
              byte_idx  <= '0;
            end else begin
              byte_idx <= byte_idx + 1'b1;
            end
          end
          default: dec_state <= DEC_CMD;
        endcase
      end else if (dec_state == DEC_PAYLOAD) begin
        if (start_edge) begin
          idle_cnt <= '0;
        end else if (rx_state == RX_IDLE) begin
          if (idle_cnt == TO_LAST) begin
            frm_err   <= 1'b1;
            dec_state <= DEC_CMD;
            byte_idx  <= '0;
            idle_cnt  <= '0;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// tb_uart_cmd_rx: directed scenarios plus randomized command streams for
// uart_cmd_rx, checked against a frame-level reference model.
`timescale 1ns/1ps

module tb_uart_cmd_rx;

  localparam int CPB = 28;
  localparam int DB  = 8;
  localparam int PB  = 4;
  localparam int PW  = PB * DB;

  logic          sclk     = 1'b0;
  logic          s_rst    = 1'b1;
  logic          rs232_rx = 1'b1;
  logic [DB-1:0] rx_data;
  logic          rx_vld;
  logic          wr_trig;
  logic [PW-1:0] wr_data;
  logic          rd_trig;
  logic          frm_err;

  uart_cmd_rx #(
    .CLK_PER_BIT  (CPB),
    .DATA_BITS    (DB),
    .PAYLOAD_BYTES(PB),
    .CMD_WR       (8'h55),
    .CMD_RD       (8'hAA),
    .TIMEOUT_BITS (20)
  ) dut (
    .sclk    (sclk),
    .s_rst   (s_rst),
    .rs232_rx(rs232_rx),
    .rx_data (rx_data),
    .rx_vld  (rx_vld),
    .wr_trig (wr_trig),
    .wr_data (wr_data),
    .rd_trig (rd_trig),
    .frm_err (frm_err)
  );

  always #10 sclk = ~sclk;

  // Comparison bookkeeping.
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: frame-level view of the command protocol.
  bit            m_payload = 1'b0;
  int            m_cnt     = 0;
  logic [PW-1:0] m_buf     = '0;
  logic [PW-1:0] m_wr_data = '0;
  int            e_vld = 0, e_wr = 0, e_rd = 0, e_err = 0;
  logic [DB-1:0] exp_q[$];

  task automatic model_char(input logic [DB-1:0] b, input bit stop_ok);
    if (!stop_ok) begin
      e_err++;
      m_payload = 1'b0;
    end else begin
      e_vld++;
      exp_q.push_back(b);
      if (m_payload) begin
        m_buf = {m_buf[PW-DB-1:0], b};
        m_cnt++;
        if (m_cnt == PB) begin
          m_wr_data = m_buf;
          e_wr++;
          m_payload = 1'b0;
        end
      end else if (b == 8'h55) begin
        m_payload = 1'b1;
        m_cnt     = 0;
      end else if (b == 8'hAA) begin
        e_rd++;
      end
    end
  endtask

  task automatic model_timeout();
    if (m_payload) begin
      e_err++;
      m_payload = 1'b0;
    end
  endtask

  task automatic model_reset();
    m_payload = 1'b0;
    m_cnt     = 0;
    m_wr_data = '0;
    exp_q.delete();
  endtask

  // Monitor: counts strobes and checks per-event properties away from the active edge.
  bit mon_en   = 1'b0;
  int cyc      = 0;
  int last_vld = -100;
  int n_vld = 0, n_wr = 0, n_rd = 0, n_err = 0;

  always @(negedge sclk) begin
    if (mon_en) begin
      cyc++;
      if (rx_vld === 1'b1) begin
        n_vld++;
        last_vld = cyc;
        if (exp_q.size() > 0) check("rx_data", rx_data, exp_q.pop_front());
        else check("rx_vld_extra", rx_vld, 0);
      end
      if (wr_trig === 1'b1) begin
        n_wr++;
        check("wr_lat", cyc - last_vld, 1);
        check("wr_rd_excl", rd_trig, 0);
        check("wr_err_excl", frm_err, 0);
      end
      if (rd_trig === 1'b1) begin
        n_rd++;
        check("rd_lat", cyc - last_vld, 1);
      end
      if (frm_err === 1'b1) n_err++;
    end
  end

  // Stimulus helpers.
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge sclk);
  endtask

  task automatic send_char(input logic [DB-1:0] b, input bit stop_ok, input int gap_bits);
    model_char(b, stop_ok);
    rs232_rx = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < DB; i++) begin
      rs232_rx = b[i];
      wait_cycles(CPB);
    end
    rs232_rx = stop_ok;
    wait_cycles(CPB);
    rs232_rx = 1'b1;
    wait_cycles(gap_bits * CPB);
  endtask

  task automatic send_glitch();
    rs232_rx = 1'b0;
    wait_cycles(10);
    rs232_rx = 1'b1;
    wait_cycles(2 * CPB);
  endtask

  task automatic checkpoint(input string tag);
    check({tag, ":rx_vld_cnt"}, n_vld, e_vld);
    check({tag, ":wr_trig_cnt"}, n_wr, e_wr);
    check({tag, ":rd_trig_cnt"}, n_rd, e_rd);
    check({tag, ":frm_err_cnt"}, n_err, e_err);
    check({tag, ":wr_data"}, wr_data, m_wr_data);
    check({tag, ":pending"}, exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ":rx_data"}, rx_data, 0);
    check({tag, ":wr_data"}, wr_data, 0);
    check({tag, ":rx_vld"}, rx_vld, 0);
    check({tag, ":wr_trig"}, wr_trig, 0);
    check({tag, ":rd_trig"}, rd_trig, 0);
    check({tag, ":frm_err"}, frm_err, 0);
  endtask

  task automatic apply_reset(input string tag);
    s_rst = 1'b1;
    wait_cycles(3);
    model_reset();
    check_reset_outputs(tag);
    s_rst = 1'b0;
    wait_cycles(2 * CPB);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DB-1:0] b;
    int kind, k;

    // Reset state.
    s_rst = 1'b1;
    wait_cycles(5);
    check_reset_outputs("reset");
    s_rst  = 1'b0;
    mon_en = 1'b1;
    wait_cycles(2 * CPB);

    // Write frame with default timing.
    send_char(8'h55, 1'b1, 1);
    send_char(8'h11, 1'b1, 1);
    send_char(8'h22, 1'b1, 1);
    send_char(8'h33, 1'b1, 1);
    send_char(8'h44, 1'b1, 2);
    checkpoint("write");
    check("write:literal", wr_data, 32'h11223344);

    // Read command leaves wr_data alone.
    send_char(8'hAA, 1'b1, 2);
    checkpoint("read");
    check("read:literal", wr_data, 32'h11223344);

    // Command codes inside a payload are data.
    send_char(8'h55, 1'b1, 1);
    send_char(8'hAA, 1'b1, 1);
    send_char(8'h55, 1'b1, 1);
    send_char(8'h01, 1'b1, 1);
    send_char(8'h02, 1'b1, 2);
    checkpoint("cmd_as_data");
    check("cmd_as_data:literal", wr_data, 32'hAA550102);

    // Payload timeout, then a read still works.
    send_char(8'h55, 1'b1, 1);
    send_char(8'h11, 1'b1, 21);
    model_timeout();
    checkpoint("timeout");
    send_char(8'hAA, 1'b1, 2);
    checkpoint("after_timeout");

    // Stop-bit error and a short glitch.
    send_char(8'h3C, 1'b0, 2);
    checkpoint("stop_err");
    send_glitch();
    checkpoint("glitch");

    // Reset in the middle of a frame, then a fresh frame.
    send_char(8'h55, 1'b1, 1);
    send_char(8'h11, 1'b1, 1);
    apply_reset("mid_reset");
    send_char(8'h55, 1'b1, 1);
    send_char(8'hA1, 1'b1, 1);
    send_char(8'hB2, 1'b1, 1);
    send_char(8'hC3, 1'b1, 1);
    send_char(8'hD4, 1'b1, 2);
    checkpoint("post_reset");
    check("post_reset:literal", wr_data, 32'hA1B2C3D4);

    // Randomized command stream.
    for (int it = 0; it < 30; it++) begin
      kind = $urandom_range(0, 10);
      if (kind <= 3) begin
        send_char(8'h55, 1'b1, $urandom_range(1, 3));
        for (int j = 0; j < PB; j++) begin
          b = DB'($urandom_range(0, 255));
          send_char(b, 1'b1, $urandom_range(1, 3));
        end
      end else if (kind <= 5) begin
        send_char(8'hAA, 1'b1, $urandom_range(1, 3));
      end else if (kind == 6) begin
        do b = DB'($urandom_range(0, 255)); while (b == 8'h55 || b == 8'hAA);
        send_char(b, 1'b1, $urandom_range(1, 3));
      end else if (kind == 7) begin
        b = DB'($urandom_range(0, 255));
        send_char(b, 1'b0, $urandom_range(1, 3));
      end else if (kind == 8) begin
        send_glitch();
      end else if (kind == 9) begin
        k = $urandom_range(1, PB - 1);
        send_char(8'h55, 1'b1, 1);
        for (int j = 0; j < k - 1; j++) begin
          b = DB'($urandom_range(0, 255));
          send_char(b, 1'b1, 1);
        end
        b = DB'($urandom_range(0, 255));
        send_char(b, 1'b1, 21);
        model_timeout();
      end else begin
        k = $urandom_range(0, PB - 1);
        send_char(8'h55, 1'b1, 1);
        for (int j = 0; j < k; j++) begin
          b = DB'($urandom_range(0, 255));
          send_char(b, 1'b1, 1);
        end
        b = DB'($urandom_range(0, 255));
        send_char(b, 1'b0, 2);
      end
      checkpoint($sformatf("rand%0d_k%0d", it, kind));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
